// File: rtl/sa48_arbiter_if.sv
// Requester/adder-side handshake bundle for sa48_arbiter.
// master = arbiter side, slave = requesters plus adder controller.
interface sa48_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  req;
    logic             adder_ready;
    logic             adder_start;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic             err;

    modport master (
        input  req, adder_ready,
        output adder_start, gnt, gnt_idx, done, busy, err
    );

    modport slave (
        output req, adder_ready,
        input  adder_start, gnt, gnt_idx, done, busy, err
    );
endinterface

// File: rtl/sa48_arbiter.sv
// Round-robin arbiter/sequencer sharing one 48-bit chunked serial adder; request-to-done 9 cycles.
// Requests are held until done; watchdog abort is built only when SA48_ARB_TIMEOUT_EN is defined.
module sa48_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    sa48_arbiter_if.master bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W:0]   idx_sum;
    logic             win_vld;
    logic             in_wait;
    logic             wd_expired;
    logic             abort;

    // First set request scanning ptr, ptr+1, ... with wrap at NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        idx_sum = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (idx_sum >= (IDX_W+1)'(NREQ)) begin
                idx_sum = idx_sum - (IDX_W+1)'(NREQ);
            end
            if (!win_vld && bus.req[idx_sum[IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = idx_sum[IDX_W-1:0];
            end
        end
    end

    assign in_wait = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        abort     = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld && bus.adder_ready) begin
                    state_d   = GRANT;
                    gnt_d     = NREQ'(1) << win_idx;
                    gnt_idx_d = win_idx;
                end
            end
            GRANT: state_d = START;
            START: state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!bus.adder_ready) begin
                    state_d = WAIT_DONE;
                end else if (wd_expired) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.adder_ready) begin
                    state_d = DONE;
                end else if (wd_expired) begin
                    state_d = DONE;
                    abort   = 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_idx_d = '0;
                ptr_d     = (gnt_idx_q == IDX_W'(NREQ-1)) ? '0 : gnt_idx_q + IDX_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
        end
    end

`ifdef SA48_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             err_q;

    // Cleared on the GRANT->START edge so it is zero on START entry.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q == GRANT) begin
            wd_cnt_d = '0;
        end else if (in_wait) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    assign wd_expired = in_wait && (wd_cnt_q == CNT_W'(TIMEOUT-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= abort;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_abort;

    assign wd_expired   = 1'b0;
    assign unused_abort = abort ^ in_wait;
    assign bus.err      = 1'b0;
`endif

    assign bus.gnt         = gnt_q;
    assign bus.gnt_idx     = gnt_idx_q;
    assign bus.adder_start = (state_q == START);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE) ? gnt_q : '0;
endmodule

// File: doc/sa48_arbiter.md
# sa48_arbiter

Round-robin arbiter and sequencer that shares one 48-bit chunked serial adder between NREQ requesters. It sits between the requesters and the adder's controller. It selects a winner, drives the operand-mux select, and pulses the adder's start line with the full rise/fall the adder controller needs. It then tracks the adder's ready line through the four 12-bit chunk cycles and returns a one-cycle done to the winner.

## Interface
- NREQ, 4: number of requesters, minimum 2.
- TIMEOUT, 16: watchdog limit in cycles. Used only when SA48_ARB_TIMEOUT_EN is defined.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level. Held high until that requester's done.
- adder_ready  input  1  adder controller resultReady. High while the adder is idle.
- adder_start  output  1  adder controller startChunks.
- gnt  output  NREQ  one-hot grant. Drives operand/result routing.
- gnt_idx  output  $clog2(NREQ)  binary index of the granted requester.
- done  output  NREQ  one-hot, one-cycle completion pulse.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse on watchdog abort. Tied 0 without the macro.

## Operation
- **States:** IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE, DONE.
- **IDLE:**
  - Moves to GRANT when |req and adder_ready.
  - Latches the winner into gnt/gnt_idx on that edge.
- **GRANT:** one cycle for operand-mux settling. Always goes to START.
- **START:**
  - adder_start=1 for exactly one cycle. Always goes to WAIT_BUSY.
  - adder_start is 0 in every other state, so the adder controller sees the fall and advances from its Starting state.
- **WAIT_BUSY:** stays until adder_ready==0, then goes to WAIT_DONE.
- **WAIT_DONE:** stays until adder_ready==1, then goes to DONE.
- **DONE:**
  - done[gnt_idx]=1 for one cycle.
  - ptr ← (gnt_idx+1) mod NREQ.
  - gnt cleared on the exit edge; goes to IDLE.
- **Arbitration:**
  - The winner is the first set req bit scanning ptr, ptr+1, … mod NREQ.
  - ptr resets to 0.
- gnt/gnt_idx stay stable from the GRANT entry edge through the DONE cycle, and are 0 in IDLE.
- A req change after the grant is ignored until IDLE. If the winner drops req mid-operation, the operation still completes and done still pulses.
- When requests collide, the lower-latency path is not favoured; only ptr order decides.
- If adder_ready is low in IDLE, no grant is issued.
- **Reset (any state, any cycle):** state=IDLE, ptr=0, and gnt, gnt_idx, adder_start, done, busy and err all 0, immediately and asynchronously.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from req or adder_ready to any output.
- With the adder controller (one-cycle Starting, four chunk cycles), for a req first seen in IDLE at cycle 0:
  - GRANT at cycle 1, START at 2.
  - WAIT_BUSY at 3, WAIT_DONE at 4–8.
  - DONE at 9, IDLE at 10.
  - Request-to-done latency is 9 cycles.
- Back-to-back requests: the next grant takes effect in the cycle after IDLE is re-entered. Issue interval is 10 cycles.
- Results are valid on the adder outputs during the DONE cycle and are captured by the requester on done.

## Configuration
- **SA48_ARB_TIMEOUT_EN defined:**
  - A counter resets on START entry and increments in WAIT_BUSY/WAIT_DONE.
  - When it reaches TIMEOUT, the arbiter pulses err for one cycle, goes to DONE (done still pulses), and advances ptr.
- **Not defined:** no counter is built, err is constant 0, and the arbiter waits indefinitely in WAIT_BUSY/WAIT_DONE.

## Test plan
- **Single request:** after reset, req=4'b0100 with the adder model attached → gnt=4'b0100, gnt_idx=2 from cycle 1; adder_start high only in cycle 2; done=4'b0100 in cycle 9; busy low at cycle 10.
- **All requesting:** req=4'b1111 held → done order 0,1,2,3,0, spaced 10 cycles apart.
- **Round-robin fairness:** req=4'b1001 with ptr=1 → grant 3 first, then 0.
- **Requester withdraws:** drop req mid-op in WAIT_DONE → done still pulses for that index; no grant to it afterwards.
- **Reset mid-op:** assert rst in WAIT_DONE → all outputs 0 in the same cycle; after release, req=4'b0010 → grant 1 (ptr=0 scan).
- **Timeout (macro on, TIMEOUT=16):** hold adder_ready low forever after start → err and done pulse together 16 cycles after START exit; next request is granted normally.
